// File: rtl/dominos_input_ctrl_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dominos_input_ctrl_if
//
// Bundle of the cabinet-side signals of the Dominos input stage.
//   master : the host side (hps_io / test harness). It drives the PS/2 key
//            stream and both joysticks and observes the game inputs.
//   slave  : the input controller. It consumes the key/joystick stream and
//            drives the active-low game inputs.
//
// Signals
//   ps2_key[10:0]     [10] event toggle, [9] pressed, [8] extended, [7:0] code
//   joystick_0/1      bit0 right, 1 left, 2 down, 3 up, 4 coin,
//                     5 start 1P, 6 start 2P (active high)
//   coin1_n/coin2_n   shaped coin pulses (active low)
//   start1_n/start2_n start buttons (active low)
//   up/down/left/right 1/2 _n  player directions (active low)
// -----------------------------------------------------------------------------
interface dominos_input_ctrl_if;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;

  logic        coin1_n;
  logic        coin2_n;
  logic        start1_n;
  logic        start2_n;
  logic        up1_n;
  logic        down1_n;
  logic        left1_n;
  logic        right1_n;
  logic        up2_n;
  logic        down2_n;
  logic        left2_n;
  logic        right2_n;

  modport master (
    output ps2_key, joystick_0, joystick_1,
    input  coin1_n, coin2_n, start1_n, start2_n,
           up1_n, down1_n, left1_n, right1_n,
           up2_n, down2_n, left2_n, right2_n
  );

  modport slave (
    input  ps2_key, joystick_0, joystick_1,
    output coin1_n, coin2_n, start1_n, start2_n,
           up1_n, down1_n, left1_n, right1_n,
           up2_n, down2_n, left2_n, right2_n
  );
endinterface

// File: rtl/dominos_input_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dominos_input_ctrl
//
// Cabinet input stage for the Dominos core. Decodes the PS/2 key event
// stream into one held bit per physical key, merges the keys with both
// joysticks, applies opposing-direction cancellation and shapes the two coin
// requests into fixed-width, rate-limited active-low pulses.
//
// Parameters
//   COIN_PULSE : coin output low time in clocks (1 .. 2^24-1)
//   COIN_GAP   : minimum high time after a pulse before re-arm (1 .. 2^24-1)
//
// Ports
//   clk_sys : system clock, all logic on its rising edge
//   reset   : asynchronous, active-high reset
//   bus     : slave side of dominos_input_ctrl_if (PS/2 key, joysticks in;
//             active-low coin/start/direction outputs)
// -----------------------------------------------------------------------------
module dominos_input_ctrl #(
  parameter int unsigned COIN_PULSE = 600000,
  parameter int unsigned COIN_GAP   = 600000
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  dominos_input_ctrl_if.slave  bus
);

  // One bit per physical key, so two keys sharing a game function are
  // tracked independently.
  localparam int K_UP1      = 0;
  localparam int K_DOWN1    = 1;
  localparam int K_LEFT1    = 2;
  localparam int K_RIGHT1   = 3;
  localparam int K_COIN_A1  = 4;
  localparam int K_COIN_B2  = 5;
  localparam int K_COIN_A2  = 6;
  localparam int K_COIN_B2B = 7;
  localparam int K_START_F1 = 8;
  localparam int K_START_F2 = 9;
  localparam int K_START1_K = 10;
  localparam int K_START2_K = 11;
  localparam int K_UP2      = 12;
  localparam int K_DOWN2    = 13;
  localparam int K_LEFT2    = 14;
  localparam int K_RIGHT2   = 15;

  localparam logic [23:0] PULSE_LOAD = 24'(COIN_PULSE - 1);
  localparam logic [23:0] GAP_LOAD   = 24'(COIN_GAP - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    HOLD  = 2'd3
  } coin_state_t;

  // ---------------------------------------------------------------------------
  // PS/2 event detection and key map
  // ---------------------------------------------------------------------------
  logic        old_tog_q;
  logic        primed_q;
  logic        ps2_event;
  logic [7:0]  scan;
  logic        ext;
  logic        pressed;
  logic [15:0] key_sel;
  logic [15:0] keys_q;
  logic [15:0] keys_d;

  assign scan    = bus.ps2_key[7:0];
  assign ext     = bus.ps2_key[8];
  assign pressed = bus.ps2_key[9];

  // The first clock after reset only captures the toggle level; whatever
  // level hps_io held across reset is not a new event.
  assign ps2_event = primed_q & (bus.ps2_key[10] ^ old_tog_q);

  always_comb begin
    key_sel = '0;
    case (scan)
      // Cursor keys arrive with the E0 prefix, keypad keys without; both
      // drive player 1, so the extended bit is ignored here.
      8'h75: key_sel[K_UP1]    = 1'b1;
      8'h72: key_sel[K_DOWN1]  = 1'b1;
      8'h6B: key_sel[K_LEFT1]  = 1'b1;
      8'h74: key_sel[K_RIGHT1] = 1'b1;
      default: begin
        // Non-extended only: e.g. E0 14 (right ctrl) must not act as coin B.
        if (!ext) begin
          case (scan)
            8'h29: key_sel[K_COIN_A1]  = 1'b1;
            8'h14: key_sel[K_COIN_B2]  = 1'b1;
            8'h2E: key_sel[K_COIN_A2]  = 1'b1;
            8'h36: key_sel[K_COIN_B2B] = 1'b1;
            8'h05: key_sel[K_START_F1] = 1'b1;
            8'h06: key_sel[K_START_F2] = 1'b1;
            8'h16: key_sel[K_START1_K] = 1'b1;
            8'h1E: key_sel[K_START2_K] = 1'b1;
            8'h2D: key_sel[K_UP2]      = 1'b1;
            8'h2B: key_sel[K_DOWN2]    = 1'b1;
            8'h23: key_sel[K_LEFT2]    = 1'b1;
            8'h34: key_sel[K_RIGHT2]   = 1'b1;
            default: ;
          endcase
        end
      end
    endcase
    if (!ps2_event) begin
      key_sel = '0;
    end
  end

  assign keys_d = (keys_q & ~key_sel) | (key_sel & {16{pressed}});

  // ---------------------------------------------------------------------------
  // Merge of keys and joysticks
  // ---------------------------------------------------------------------------
  logic [15:0] joy0;
  logic [15:0] joy1;
  logic        p1_up, p1_down, p1_left, p1_right;
  logic        p2_up, p2_down, p2_left, p2_right;
  logic        start1, start2;
  logic [1:0]  req_d;

  logic        unused_joy;

  assign joy0 = bus.joystick_0;
  assign joy1 = bus.joystick_1;
  assign unused_joy = ^{joy0[15:7], joy1[15:7]};

  always_comb begin
    p1_up    = keys_q[K_UP1]    | joy0[3];
    p1_down  = keys_q[K_DOWN1]  | joy0[2];
    p1_left  = keys_q[K_LEFT1]  | joy0[1];
    p1_right = keys_q[K_RIGHT1] | joy0[0];

    p2_up    = keys_q[K_UP2]    | joy1[3];
    p2_down  = keys_q[K_DOWN2]  | joy1[2];
    p2_left  = keys_q[K_LEFT2]  | joy1[1];
    p2_right = keys_q[K_RIGHT2] | joy1[0];

    start1   = keys_q[K_START_F1] | keys_q[K_START1_K] | joy0[5] | joy1[5];
    start2   = keys_q[K_START_F2] | keys_q[K_START2_K] | joy0[6] | joy1[6];

    req_d[0] = keys_q[K_COIN_A1] | keys_q[K_COIN_A2]  | joy0[4];
    req_d[1] = keys_q[K_COIN_B2] | keys_q[K_COIN_B2B] | joy1[4];
  end

  // ---------------------------------------------------------------------------
  // Registered game inputs (active low) and coin request history
  // ---------------------------------------------------------------------------
  logic       start1_n_q, start2_n_q;
  logic       up1_n_q, down1_n_q, left1_n_q, right1_n_q;
  logic       up2_n_q, down2_n_q, left2_n_q, right2_n_q;
  logic [1:0] req_q;
  logic [1:0] req_prev_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      old_tog_q  <= 1'b0;
      primed_q   <= 1'b0;
      keys_q     <= '0;
      start1_n_q <= 1'b1;
      start2_n_q <= 1'b1;
      up1_n_q    <= 1'b1;
      down1_n_q  <= 1'b1;
      left1_n_q  <= 1'b1;
      right1_n_q <= 1'b1;
      up2_n_q    <= 1'b1;
      down2_n_q  <= 1'b1;
      left2_n_q  <= 1'b1;
      right2_n_q <= 1'b1;
      // Request history starts as "held": a coin held through reset must be
      // released and pressed again before it produces a pulse.
      req_q      <= 2'b11;
      req_prev_q <= 2'b11;
    end else begin
      old_tog_q  <= bus.ps2_key[10];
      primed_q   <= 1'b1;
      keys_q     <= keys_d;
      start1_n_q <= ~start1;
      start2_n_q <= ~start2;
      // Opposing directions pressed together cancel to "neither".
      up1_n_q    <= ~(p1_up    & ~p1_down);
      down1_n_q  <= ~(p1_down  & ~p1_up);
      left1_n_q  <= ~(p1_left  & ~p1_right);
      right1_n_q <= ~(p1_right & ~p1_left);
      up2_n_q    <= ~(p2_up    & ~p2_down);
      down2_n_q  <= ~(p2_down  & ~p2_up);
      left2_n_q  <= ~(p2_left  & ~p2_right);
      right2_n_q <= ~(p2_right & ~p2_left);
      req_q      <= req_d;
      req_prev_q <= req_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Coin pulse shapers, one independent FSM per channel
  // ---------------------------------------------------------------------------
  logic [1:0] coin_pulse;

  for (genvar ch = 0; ch < 2; ch++) begin : g_coin
    coin_state_t state_q;
    logic [23:0] cnt_q;

    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (req_q[ch] && !req_prev_q[ch]) begin
              state_q <= PULSE;
              cnt_q   <= PULSE_LOAD;
            end
          end
          PULSE: begin
            if (cnt_q == 24'd0) begin
              state_q <= GAP;
              cnt_q   <= GAP_LOAD;
            end else begin
              cnt_q <= cnt_q - 24'd1;
            end
          end
          GAP: begin
            // A request still held at the end of the gap must be released
            // first; edges seen while busy are dropped, not queued.
            if (cnt_q == 24'd0) begin
              state_q <= req_q[ch] ? HOLD : IDLE;
            end else begin
              cnt_q <= cnt_q - 24'd1;
            end
          end
          HOLD: begin
            if (!req_q[ch]) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end

    // Pure decode of the state register, so the pulse has no glitches.
    assign coin_pulse[ch] = (state_q == PULSE);
  end

  assign bus.coin1_n  = ~coin_pulse[0];
  assign bus.coin2_n  = ~coin_pulse[1];
  assign bus.start1_n = start1_n_q;
  assign bus.start2_n = start2_n_q;
  assign bus.up1_n    = up1_n_q;
  assign bus.down1_n  = down1_n_q;
  assign bus.left1_n  = left1_n_q;
  assign bus.right1_n = right1_n_q;
  assign bus.up2_n    = up2_n_q;
  assign bus.down2_n  = down2_n_q;
  assign bus.left2_n  = left2_n_q;
  assign bus.right2_n = right2_n_q;

endmodule

// File: doc/dominos_input_ctrl.md
# dominos_input_ctrl

Cabinet input stage for the Dominos core, sitting between `hps_io` and the `dominos` game module. It decodes the PS/2 key stream into held key state and merges it with both joysticks. It drives the game's active-low player inputs with opposing-direction cancellation. Coin requests are turned into fixed-width, rate-limited coin pulses so the game's coin logic sees clean edges regardless of how long a key is held.

## Interface
- `COIN_PULSE`, default 600000: coin output low time in clocks (50 ms at 12 MHz); legal range 1..2^24-1.
- `COIN_GAP`, default 600000: minimum high time after a coin pulse before re-arm; legal range 1..2^24-1.

- `clk_sys` in 1: system clock (12 MHz); all logic on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `ps2_key` in 11: [10] event toggle, [9] pressed, [8] extended, [7:0] scancode.
- `joystick_0`, `joystick_1` in 16 each: bit0 right, 1 left, 2 down, 3 up, 4 coin, 5 start 1P, 6 start 2P; active high.
- `coin1_n`, `coin2_n` out 1: shaped coin pulses, active low.
- `start1_n`, `start2_n` out 1: start buttons, active low.
- `up1_n`, `down1_n`, `left1_n`, `right1_n` out 1: player 1 directions, active low.
- `up2_n`, `down2_n`, `left2_n`, `right2_n` out 1: player 2 directions, active low.

## Operation
- **Reset values:**
  - All outputs are 1.
  - All key bits are 0.
  - Coin FSMs are IDLE with counters at 0.
  - `primed` is 0.
- **Toggle detect:**
  - First clock after reset: store `ps2_key[10]` into `old_tog`, set `primed`, and process nothing.
  - Afterwards, an event occurs when `primed` and `ps2_key[10] != old_tog`.
  - `old_tog` updates every clock.
- **Key map** (on event, set the bit to `ps2_key[9]`; unlisted codes are ignored):
  - Extended bit ignored: 0x75 up1, 0x72 down1, 0x6B left1, 0x74 right1.
  - Extended must be 0: 0x029 coinA1, 0x014 coinB2, 0x02E coinA2, 0x036 coinB2b, 0x005 startF1, 0x006 startF2, 0x016 start1k, 0x01E start2k, 0x02D up2, 0x02B down2, 0x023 left2, 0x034 right2.
  - Each physical key has its own bit. Releasing one key never clears another key mapped to the same function.
- **Merge** (registered, one clock):
  - `coin1_req = coinA1 | coinA2 | joy0[4]`.
  - `coin2_req = coinB2 | coinB2b | joy1[4]`.
  - `start1 = startF1 | start1k | joy0[5] | joy1[5]`.
  - `start2 = startF2 | start2k | joy0[6] | joy1[6]`.
  - P1 directions are keys OR `joystick_0`; P2 directions are keys OR `joystick_1`.
- **Cancellation:** if up and down are both active, both outputs are 1. Same rule for left and right, per player.
- **Coin FSM, per channel** (states IDLE, PULSE, GAP, HOLD):
  - IDLE: a `req` rising edge (`req_q=1`, previous `req_q=0`) moves to PULSE and loads the counter with COIN_PULSE-1.
  - PULSE: counter decrements; at 0, move to GAP and load COIN_GAP-1.
  - GAP: counter decrements; at 0, go to HOLD if `req_q=1`, else IDLE.
  - HOLD: wait until `req_q=0`, then go to IDLE.
  - `coinN_n = ~(state==PULSE)`, decoded from the state register (no glitches).
  - Request edges during PULSE, GAP or HOLD are discarded, not queued.
- A `reset` assertion at any time, including mid-pulse, immediately forces all reset values.

## Timing
- A PS/2 event sampled at edge k updates the key bit at k. The merged direction/start output changes at edge k+1.
- A joystick change sampled at edge k shows on direction/start outputs at edge k.
- **Coin:**
  - `req_q` rises at edge k and the FSM enters PULSE at k+1.
  - `coin_n` is low for exactly COIN_PULSE clocks, then high for at least COIN_GAP clocks.
  - With continuous press/release, at most one pulse per COIN_PULSE+COIN_GAP+1 clocks.
- Both coin channels are fully independent and may pulse in the same cycle.

## Test plan
(All coin tests use COIN_PULSE=4, COIN_GAP=3.)
- **Reset / priming:** hold `reset` with `ps2_key=11'h475`, then release → all outputs 1 and `up1_n` stays 1; later toggle with 0x275 → `up1_n=0` two edges after the toggle edge.
- **Shared function:** press space (0x229), press 5 (0x22E), release space (0x029) → `coin1_req` stays 1; release 5 → `coin1_req` 0; exactly one 4-clock `coin1_n` low pulse.
- **Held coin:** hold `joystick_0[4]` for 50 clocks → exactly one pulse of 4 clocks; release then re-press in GAP → no pulse; re-press after HOLD→IDLE → second pulse.
- **Cancellation:** `joystick_1` = 0x000C (up+down) → `up2_n=down2_n=1`; drop bit2 → `up2_n=0`, `down2_n=1` at that edge.
- **Extended handling:** event 0x175 (E0 75) → `up1_n=0`; event 0x114 (right ctrl) → `coin2_n` unchanged.
- **Reset mid-pulse:** assert `reset` on the 2nd PULSE clock → `coin1_n=1` immediately; after release with request held, FSM IDLE, and no pulse until the request falls and rises again.
